// File: rtl/quad_pkg.sv
// Shared types and step-decode helpers for the quadrature decoder.
// A quadrature state {A,B} maps onto a 2-bit Gray position used for direction decoding.
package quad_pkg;

    typedef logic [1:0] quad_t;

    typedef enum logic {
        INIT,
        TRACK
    } fsm_state_e;

    typedef enum logic [1:0] {
        NONE,
        UP,
        DOWN,
        ILLEGAL
    } step_e;

    // 00 -> 0, 01 -> 1, 11 -> 2, 10 -> 3 along the up sequence.
    function automatic logic [1:0] gray_idx(input quad_t q);
        return {q[1], q[1] ^ q[0]};
    endfunction

    function automatic step_e decode_step(input quad_t old_q, input quad_t new_q);
        logic [1:0] delta;
        delta = gray_idx(new_q) - gray_idx(old_q);
        case (delta)
            2'd0:    return NONE;
            2'd1:    return UP;
            2'd3:    return DOWN;
            default: return ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Signal bundle between the quadrature decoder and its user.
// CE and Err are single-cycle strobes with no back-pressure; UpDown is meaningful only while CE=1.
interface quad_decoder_if #(
    parameter int WIDTH = 8
) ();

    logic             A;
    logic             B;
    logic             En;
    logic             Clear;
    logic             CE;
    logic             UpDown;
    logic [WIDTH-1:0] Position;
    logic             Err;
    logic [WIDTH-1:0] ErrCount;
    logic             Locked;
    quad_pkg::fsm_state_e state;

    modport master (
        output A, B, En, Clear,
        input  CE, UpDown, Position, Err, ErrCount, Locked, state
    );

    modport slave (
        input  A, B, En, Clear,
        output CE, UpDown, Position, Err, ErrCount, Locked, state
    );

endinterface

// File: rtl/quad_input_filter.sv
// Synchronizes A/B and accepts a new {A,B} value once it has been stable for FILTER_LEN clocks.
// f_prev keeps the value F held before its latest update so the decoder can compare old against new.
module quad_input_filter
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  a,
    input  logic  b,
    output quad_t f,
    output quad_t f_prev,
    output logic  accepted
);

    quad_t      sync1;
    quad_t      sync2;
    quad_t      s_last;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       accept;

    // cnt_next is the number of consecutive sampled clocks S has held its present value.
    always_comb begin
        cnt_next = 4'd1;
        if (sync2 == s_last) begin
            cnt_next = (cnt == 4'hF) ? cnt : cnt + 4'd1;
        end
        accept = (cnt_next >= 4'(FILTER_LEN)) && (sync2 != f);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            s_last   <= '0;
            cnt      <= '0;
            f        <= '0;
            f_prev   <= '0;
            accepted <= 1'b0;
        end else begin
            sync1    <= {a, b};
            sync2    <= sync1;
            s_last   <= sync2;
            cnt      <= cnt_next;
            accepted <= accept;
            if (accept) begin
                f      <= sync2;
                f_prev <= f;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B edges become CE/UpDown steps, a wrapping position
// count and a saturating illegal-transition count.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int WIDTH      = 8
) (
    input logic           clock,
    input logic           reset,
    quad_decoder_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    quad_t            f;
    quad_t            f_prev;
    logic             accepted;
    step_e            step;

    fsm_state_e       state_q, state_d;
    logic             ce_q, ce_d;
    logic             updown_q, updown_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] errcnt_q, errcnt_d;

    quad_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clock    (clock),
        .reset    (reset),
        .a        (bus.A),
        .b        (bus.B),
        .f        (f),
        .f_prev   (f_prev),
        .accepted (accepted)
    );

    assign step = decode_step(f_prev, f);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= INIT;
            ce_q     <= 1'b0;
            updown_q <= 1'b0;
            err_q    <= 1'b0;
            pos_q    <= '0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ce_q     <= ce_d;
            updown_q <= updown_d;
            err_q    <= err_d;
            pos_q    <= pos_d;
            errcnt_q <= errcnt_d;
        end
    end

    // The first accepted state after reset only establishes a reference; it never counts.
    always_comb begin
        state_d  = state_q;
        ce_d     = 1'b0;
        updown_d = updown_q;
        err_d    = 1'b0;
        pos_d    = pos_q;
        errcnt_d = errcnt_q;
        if (accepted) begin
            if (state_q == INIT) begin
                state_d = TRACK;
            end else begin
                case (step)
                    UP: begin
                        if (bus.En) begin
                            ce_d     = 1'b1;
                            updown_d = 1'b1;
                            pos_d    = pos_q + ONE;
                        end
                    end
                    DOWN: begin
                        if (bus.En) begin
                            ce_d     = 1'b1;
                            updown_d = 1'b0;
                            pos_d    = pos_q - ONE;
                        end
                    end
                    ILLEGAL: begin
                        err_d = 1'b1;
                        if (errcnt_q != '1) begin
                            errcnt_d = errcnt_q + ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (bus.Clear) begin
            pos_d    = '0;
            errcnt_d = '0;
        end
    end

    assign bus.CE       = ce_q;
    assign bus.UpDown   = updown_q;
    assign bus.Err      = err_q;
    assign bus.Position = pos_q;
    assign bus.ErrCount = errcnt_q;
    assign bus.Locked   = (state_q == TRACK);
    assign bus.state    = state_q;

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 4, range 2..15: consecutive clocks a synchronized {A,B} value must be stable before it is accepted.
REQ-002 Parameter WIDTH, default 8: width of Position and ErrCount.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 A  input  1  quadrature channel A, asynchronous to clock.
REQ-006 B  input  1  quadrature channel B, asynchronous to clock.
REQ-007 En  input  1  enable for step output and Position update.
REQ-008 Clear  input  1  synchronous clear of Position and ErrCount.
REQ-009 CE  output  1  one-cycle step strobe, drives a downstream up/down counter's count enable.
REQ-010 UpDown  output  1  step direction, 1 = up, valid whenever CE = 1, holds its last value otherwise.
REQ-011 Position  output  WIDTH  internal up/down step count.
REQ-012 Err  output  1  one-cycle strobe on an illegal transition.
REQ-013 ErrCount  output  WIDTH  saturating illegal-transition count.
REQ-014 Locked  output  1  high while the FSM is in TRACK.

Function
REQ-015 A and B each pass through a two-flop synchronizer, forming the 2-bit vector S = {A,B}.
REQ-016 Filter: a stability counter resets on any change of S and increments otherwise, saturating. The filtered state F loads S when S has been stable for FILTER_LEN clocks and S != F.
REQ-017 FSM states: INIT, TRACK. Reset enters INIT.
REQ-018 In INIT, the first filter acceptance loads F, moves to TRACK, and emits no CE and no Err.
REQ-019 In TRACK, every F update is decoded from old F to new F in the same cycle. CE, UpDown and Err are registered and are visible the cycle after F updates.
REQ-020 Up sequence: 00->01->11->10->00. Each single-step transition in this sequence gives CE=1, UpDown=1.
REQ-021 Down sequence: the reverse of REQ-020. Each single-step transition gives CE=1, UpDown=0.
REQ-022 A transition that changes both bits (00<->11 or 01<->10) gives Err=1, CE=0, UpDown unchanged and Position unchanged.
REQ-023 Total latency: an input change settled before rising edge k gives CE high after edge k+FILTER_LEN+2 (7 edges for the default).
REQ-024 Position increments on an up step and decrements on a down step, wrapping modulo 2^WIDTH (max+1 -> 0, 0-1 -> max).
REQ-025 ErrCount increments on each Err and saturates at 2^WIDTH-1.
REQ-026 En=0: F and the FSM still track, while CE is forced 0 and Position holds. Err and ErrCount still update. Re-enabling produces no catch-up steps.
REQ-027 Clear=1 zeroes Position and ErrCount next cycle, taking priority over a simultaneous step or error. CE and Err still pulse normally.
REQ-028 Each F update yields at most one CE or Err pulse, never both.

Reset
REQ-029 While reset is low, all outputs are 0: CE, UpDown, Err, Locked, Position, ErrCount.
REQ-030 Reset also clears the synchronizers, stability counter, F and the FSM (to INIT).
REQ-031 Reset asserted mid-transition aborts any pending step. After release, the block re-enters INIT and emits no step for the first accepted state.

Structure
REQ-032 Shared package quad_pkg holds the 2-bit quadrature state typedef, the FSM enum (INIT, TRACK) and the step-decode constants (NONE, UP, DOWN, ILLEGAL).
REQ-033 One sub-module, quad_input_filter, holds the synchronizers, stability counter and F register, and outputs F plus a one-cycle "accepted" strobe.

Verification
REQ-034 After reset release, hold {A,B}=10 for 20 clocks -> Locked=1 at edge FILTER_LEN+3, no CE, Position=0.
REQ-035 Drive 4 full up cycles (16 steps), each state held 10 clocks -> 16 CE pulses with UpDown=1 and Position=16. Then 17 down steps -> Position=255 (wrap).
REQ-036 Glitch: A toggles for 3 clocks (FILTER_LEN=4) then returns -> no CE, no Err, Position unchanged.
REQ-037 Jump 00->11 -> Err for 1 cycle, ErrCount=1, Position unchanged. 256 such errors -> ErrCount=255 (saturated).
REQ-038 En=0 during 5 up steps, then En=1 -> no CE, Position unchanged. The next up step gives exactly one CE.
REQ-039 Clear asserted on the same cycle as a step's CE -> Position=0 next cycle. Reset asserted mid-filter -> all outputs 0, INIT re-entered, no spurious CE.
